// File: rtl/lambda_call_pkg.sv
// Shared types for the call arbiter: FSM state encoding and default data width.
package lambda_call_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RETURN = 2'd2
    } call_state_e;

endpackage

// File: rtl/call_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after the pointer,
// wrapping modulo NUM_CALLERS (also correct for non-power-of-2 counts).
module rr_pick
    import lambda_call_pkg::*;
#(
    parameter int NUM_CALLERS = 2,
    parameter int IDX_W       = 3
) (
    input  logic [NUM_CALLERS-1:0] request,
    input  logic [IDX_W-1:0]       pointer,
    output logic [IDX_W-1:0]       grant,
    output logic                   grant_valid
);

    logic hit_s;

    function automatic logic [IDX_W:0] wrap_idx(input logic [IDX_W-1:0] base, input int offset);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + (IDX_W+1)'(offset);
        if (sum >= (IDX_W+1)'(NUM_CALLERS)) begin
            wrap_idx = sum - (IDX_W+1)'(NUM_CALLERS);
        end else begin
            wrap_idx = sum;
        end
    endfunction

    // Scan offsets from farthest to nearest so the nearest hit is the last one written.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        hit_s       = 1'b0;
        for (int i = NUM_CALLERS; i >= 1; i--) begin
            for (int j = 0; j < NUM_CALLERS; j++) begin
                hit_s       = request[j] && (wrap_idx(pointer, i) == (IDX_W+1)'(j));
                grant       = hit_s ? IDX_W'(j) : grant;
                grant_valid = grant_valid | hit_s;
            end
        end
    end

endmodule

// File: rtl/call_arbiter.sv
// Lets NUM_CALLERS callers share one callee: round-robin grant, latched arguments,
// result returned to the granted caller with a one-cycle out pulse.
module call_arbiter
    import lambda_call_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int NUM_CALLERS = 2,
    parameter int IDX_W       = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CALLERS-1:0]       caller_request,
    input  logic [NUM_CALLERS*WIDTH-1:0] caller_in1,
    input  logic [NUM_CALLERS*WIDTH-1:0] caller_in2,
    output logic [NUM_CALLERS-1:0]       caller_out,
    output logic [WIDTH-1:0]             caller_result,
    output logic                         callee_request,
    output logic [WIDTH-1:0]             callee_in1,
    output logic [WIDTH-1:0]             callee_in2,
    input  logic                         callee_out,
    input  logic [WIDTH-1:0]             callee_result,
    output logic                         busy
);

    call_state_e state_r;
    call_state_e state_s;

    logic [IDX_W-1:0]       pick_grant_s;
    logic                   pick_valid_s;
    logic [WIDTH-1:0]       sel_in1_s;
    logic [WIDTH-1:0]       sel_in2_s;

    logic [IDX_W-1:0]       grant_r;
    logic [IDX_W-1:0]       ptr_r;
    logic [WIDTH-1:0]       arg1_r;
    logic [WIDTH-1:0]       arg2_r;
    logic [WIDTH-1:0]       result_r;

    logic                   callee_request_s;
    logic                   busy_s;
    logic [NUM_CALLERS-1:0] caller_out_s;
    logic                   callee_request_r;
    logic                   busy_r;
    logic [NUM_CALLERS-1:0] caller_out_r;

    function automatic logic [NUM_CALLERS-1:0] grant_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_CALLERS-1:0] vec;
        vec = '0;
        for (int k = 0; k < NUM_CALLERS; k++) begin
            vec[k] = (idx == IDX_W'(k));
        end
        return vec;
    endfunction

    rr_pick #(
        .NUM_CALLERS (NUM_CALLERS),
        .IDX_W       (IDX_W)
    ) u_rr_pick (
        .request     (caller_request),
        .pointer     (ptr_r),
        .grant       (pick_grant_s),
        .grant_valid (pick_valid_s)
    );

    // Argument mux selecting the winning caller's slices.
    always_comb begin
        sel_in1_s = '0;
        sel_in2_s = '0;
        for (int k = 0; k < NUM_CALLERS; k++) begin
            sel_in1_s = (pick_grant_s == IDX_W'(k)) ? caller_in1[k*WIDTH +: WIDTH] : sel_in1_s;
            sel_in2_s = (pick_grant_s == IDX_W'(k)) ? caller_in2[k*WIDTH +: WIDTH] : sel_in2_s;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; the callee has no timeout, so ISSUE waits indefinitely.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = pick_valid_s ? ISSUE : IDLE;
            ISSUE:   state_s = callee_out ? RETURN : ISSUE;
            RETURN:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode from the next state so the output registers line up with state_r.
    always_comb begin
        callee_request_s = (state_s == ISSUE);
        busy_s           = (state_s != IDLE);
        if (state_s == RETURN) begin
            caller_out_s = grant_onehot(grant_r);
        end else begin
            caller_out_s = '0;
        end
    end

    // Output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            callee_request_r <= 1'b0;
            busy_r           <= 1'b0;
            caller_out_r     <= '0;
        end else begin
            callee_request_r <= callee_request_s;
            busy_r           <= busy_s;
            caller_out_r     <= caller_out_s;
        end
    end

    // Datapath: grant/argument latch, result capture and pointer update.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_r  <= '0;
            ptr_r    <= IDX_W'(NUM_CALLERS - 1);
            arg1_r   <= '0;
            arg2_r   <= '0;
            result_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        grant_r <= pick_grant_s;
                        arg1_r  <= sel_in1_s;
                        arg2_r  <= sel_in2_s;
                    end
                end
                ISSUE: begin
                    if (callee_out) begin
                        result_r <= callee_result;
                    end
                end
                RETURN: begin
                    ptr_r <= grant_r;
                end
                default: begin
                    ptr_r <= ptr_r;
                end
            endcase
        end
    end

    assign callee_request = callee_request_r;
    assign callee_in1     = arg1_r;
    assign callee_in2     = arg2_r;
    assign caller_out     = caller_out_r;
    assign caller_result  = result_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_call_arbiter.sv
// Scoreboard bench for call_arbiter: directed calls push expected (caller, result)
// pairs; a monitor pops and compares on every caller_out pulse.
module tb_call_arbiter;

    localparam int WIDTH = 32;
    localparam int N     = 2;
    localparam int IDX_W = 3;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [N-1:0]       caller_request;
    logic [N*WIDTH-1:0] caller_in1 = '0;
    logic [N*WIDTH-1:0] caller_in2 = '0;
    logic [N-1:0]       caller_out;
    logic [WIDTH-1:0]   caller_result;
    logic               callee_request;
    logic [WIDTH-1:0]   callee_in1;
    logic [WIDTH-1:0]   callee_in2;
    logic               callee_out;
    logic [WIDTH-1:0]   callee_result;
    logic               busy;

    logic               model_out = 1'b0;
    logic [WIDTH-1:0]   model_res = '0;
    logic               spur_out  = 1'b0;
    logic [WIDTH-1:0]   spur_res  = '0;
    int                 lat = 1;
    int                 issued[N];
    int                 served[N];

    typedef struct {
        int             idx;
        logic [WIDTH-1:0] res;
    } exp_t;
    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    call_arbiter #(.WIDTH(WIDTH), .NUM_CALLERS(N), .IDX_W(IDX_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .caller_request (caller_request),
        .caller_in1     (caller_in1),
        .caller_in2     (caller_in2),
        .caller_out     (caller_out),
        .caller_result  (caller_result),
        .callee_request (callee_request),
        .callee_in1     (callee_in1),
        .callee_in2     (callee_in2),
        .callee_out     (callee_out),
        .callee_result  (callee_result),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    assign callee_out    = model_out | spur_out;
    assign callee_result = spur_out ? spur_res : model_res;

    // A caller holds its request while it has calls not yet answered.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            caller_request[k] = (issued[k] != served[k]);
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_args(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        caller_in1[k*WIDTH +: WIDTH] = a;
        caller_in2[k*WIDTH +: WIDTH] = b;
    endtask

    task automatic call(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        set_args(k, a, b);
        e.idx = k;
        e.res = a + b;
        exp_q.push_back(e);
        issued[k]++;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || caller_request != '0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        vectors++;
        if (n >= 200) begin
            miscompares++;
            $display("FAIL %s_timeout: busy=%0d pending=%0d, expected idle within 200 cycles", name, busy, exp_q.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < N; k++) issued[k] = served[k];
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Callee model: adder answering lat cycles after it sees its request.
    initial begin : callee_model
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clock);
            #1;
            if (callee_request && !model_out) begin
                cnt++;
                if (cnt >= lat) begin
                    model_out = 1'b1;
                    model_res = callee_in1 + callee_in2;
                end
            end else begin
                model_out = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: every out pulse must match the oldest outstanding expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (caller_out != '0) begin
                check("out_onehot", WIDTH'($onehot(caller_out)), WIDTH'(1));
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out: caller_out=%b, expected no pulse", caller_out);
                end else begin
                    e = exp_q.pop_front();
                    check("grant", WIDTH'(caller_out), WIDTH'(1) << e.idx);
                    check("result", caller_result, e.res);
                end
                for (int k = 0; k < N; k++) begin
                    if (caller_out[k] && served[k] < issued[k]) served[k]++;
                end
            end
        end
    end

    initial begin : driver
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", WIDTH'(busy), 0);
        check("rst_callee_request", WIDTH'(callee_request), 0);
        check("rst_caller_out", WIDTH'(caller_out), 0);
        check("rst_caller_result", caller_result, 0);
        check("rst_callee_in1", callee_in1, 0);
        reset = 1'b1;

        // Single call
        @(negedge clock);
        call(0, 5, 7);
        check("t1_req_not_yet", WIDTH'(callee_request), 0);
        @(posedge clock); #1;
        check("t1_callee_request", WIDTH'(callee_request), 1);
        check("t1_callee_in1", callee_in1, 5);
        check("t1_callee_in2", callee_in2, 7);
        check("t1_busy", WIDTH'(busy), 1);
        wait_idle("t1");
        check("t1_busy_after", WIDTH'(busy), 0);
        check("t1_out_cleared", WIDTH'(caller_out), 0);

        // Simultaneous after reset: caller 0 first
        do_reset();
        @(negedge clock);
        call(0, 1, 1);
        call(1, 10, 20);
        wait_idle("t2");

        // Fairness: 0,1,0,1,0,1
        @(negedge clock);
        for (int r = 0; r < 3; r++) begin
            call(0, 4, 4);
            call(1, 6, 9);
        end
        wait_idle("t3");

        // Argument stability with a slow callee
        lat = 4;
        @(negedge clock);
        call(0, 3, 2);
        @(posedge clock); #1;
        check("t4_callee_in1_grant", callee_in1, 3);
        set_args(0, 99, 2);
        repeat (2) @(negedge clock);
        check("t4_issue_hold", WIDTH'(callee_request), 1);
        check("t4_callee_in1_stable", callee_in1, 3);
        wait_idle("t4");

        // Reset mid-call abandons it and restores caller 0 priority
        @(negedge clock);
        set_args(1, 7, 7);
        issued[1]++;
        @(posedge clock); #1;
        check("t5_in_issue", WIDTH'(callee_request), 1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("t5_rst_callee_request", WIDTH'(callee_request), 0);
        check("t5_rst_caller_out", WIDTH'(caller_out), 0);
        check("t5_rst_busy", WIDTH'(busy), 0);
        issued[1] = served[1];
        @(negedge clock);
        reset = 1'b1;
        lat = 1;
        @(negedge clock);
        call(0, 1, 2);
        call(1, 10, 20);
        wait_idle("t5");

        // Spurious callee completion while idle
        @(negedge clock);
        spur_res = 777;
        spur_out = 1'b1;
        @(negedge clock);
        spur_out = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("t6_no_out", WIDTH'(caller_out), 0);
        end
        check("t6_busy", WIDTH'(busy), 0);
        check("t6_result_held", caller_result, 30);
        check("queue_drained", WIDTH'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
